// File: rtl/spi_sub_if.sv
// SPI pins and AES-side block handshake for the spi_sub endpoint.
// slave modport is the endpoint's view; master is the SPI main / AES core view.
interface spi_sub_if #(
    parameter int DATA_W = 128
);
    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic [0:DATA_W-1] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [0:DATA_W-1] rx_data;
    logic              rx_valid;
    logic              busy;

    modport slave (
        input  sclk, cs_n, mosi, tx_data, tx_valid,
        output miso, tx_ready, rx_data, rx_valid, busy
    );

    modport master (
        output sclk, cs_n, mosi, tx_data, tx_valid,
        input  miso, tx_ready, rx_data, rx_valid, busy
    );
endinterface

// File: rtl/spi_sub.sv
// SPI subordinate endpoint: oversampled sclk/cs_n/mosi, full-duplex DATA_W-bit frames.
// Optional macro SPI_SUB_ECHO_EN: an empty holding register sends the last received block.
//
// state     | meaning
// WAIT_HIGH | after reset, wait for a settled cs_n=1 before accepting frames
// IDLE      | between frames, waiting for cs_n to fall
// SHIFT     | frame in progress, one bit per sclk falling edge
// DONE      | full block received, ignore sclk until cs_n rises
module spi_sub #(
    parameter int DATA_W      = 128,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    spi_sub_if.slave     bus
);
    localparam int CW = $clog2(DATA_W) + 1;
    localparam int PW = $clog2(SYNC_STAGES + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

    typedef enum logic [1:0] {
        WAIT_HIGH = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sr, cs_sr, mosi_sr;
    logic                   sclk_prev, cs_prev;
    logic                   sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_fall, cs_fall, cs_rise;
    logic [PW-1:0]          prime_cnt;
    logic                   primed;

    logic [0:DATA_W-1] hold_data;
    logic              hold_full;
    logic              tx_hs;
    logic [0:DATA_W-1] load_word;
    logic [0:DATA_W-1] tx_shift;
    logic [0:DATA_W-2] rx_shift;
    logic [0:DATA_W-1] rx_data_q;
    logic              rx_valid_q;
    logic [CW-1:0]     bit_cnt;

    logic start_frame, shift_bit, finish_frame, abort_frame;

    // Synchronizers; cs_n chain resets high so reset never fabricates a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sr   <= '0;
            cs_sr     <= '1;
            mosi_sr   <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], bus.sclk};
            cs_sr     <= {cs_sr[SYNC_STAGES-2:0], bus.cs_n};
            mosi_sr   <= {mosi_sr[SYNC_STAGES-2:0], bus.mosi};
            sclk_prev <= sclk_sync;
            cs_prev   <= cs_sync;
        end
    end

    assign sclk_sync = sclk_sr[SYNC_STAGES-1];
    assign cs_sync   = cs_sr[SYNC_STAGES-1];
    assign mosi_sync = mosi_sr[SYNC_STAGES-1];
    assign sclk_fall = sclk_prev & ~sclk_sync;
    assign cs_fall   = cs_prev & ~cs_sync;
    assign cs_rise   = ~cs_prev & cs_sync;

    // The cs_n chain still holds its reset value for SYNC_STAGES cycles; WAIT_HIGH
    // must not trust it until real samples have flushed it, or a reset released
    // with cs_n low would look like an idle line followed by a fresh frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            prime_cnt <= PW'(SYNC_STAGES);
        end else if (prime_cnt != '0) begin
            prime_cnt <= prime_cnt - 1'b1;
        end
    end

    assign primed = (prime_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_HIGH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        start_frame  = 1'b0;
        shift_bit    = 1'b0;
        finish_frame = 1'b0;
        abort_frame  = 1'b0;
        case (state_q)
            WAIT_HIGH: begin
                if (primed && cs_sync) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (cs_fall) begin
                    start_frame = 1'b1;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                // cs_rise outranks a coincident sclk_fall
                if (cs_rise) begin
                    abort_frame = 1'b1;
                    state_d     = IDLE;
                end else if (sclk_fall) begin
                    shift_bit = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        finish_frame = 1'b1;
                        state_d      = DONE;
                    end
                end
            end
            DONE: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end
            end
            default: state_d = WAIT_HIGH;
        endcase
    end

    assign tx_hs = bus.tx_valid & ~hold_full;

`ifdef SPI_SUB_ECHO_EN
    assign load_word = hold_full ? hold_data : rx_data_q;
`else
    assign load_word = hold_full ? hold_data : '0;
`endif

    // Holding register: a handshake on the frame-start cycle only happens when the
    // register is empty, so the new word is kept for the following frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data <= '0;
            hold_full <= 1'b0;
        end else if (tx_hs) begin
            hold_data <= bus.tx_data;
            hold_full <= 1'b1;
        end else if (start_frame) begin
            hold_full <= 1'b0;
        end
    end

    // miso is tx_shift[0]; clearing tx_shift parks miso low outside a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift   <= '0;
            rx_shift   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            bit_cnt    <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            if (start_frame) begin
                tx_shift <= load_word;
                bit_cnt  <= '0;
            end
            if (shift_bit) begin
                rx_shift <= {rx_shift[1:DATA_W-2], mosi_sync};
                tx_shift <= {tx_shift[1:DATA_W-1], 1'b0};
                bit_cnt  <= bit_cnt + 1'b1;
            end
            if (finish_frame) begin
                rx_data_q  <= {rx_shift, mosi_sync};
                rx_valid_q <= 1'b1;
                tx_shift   <= '0;
            end
            if (abort_frame) begin
                tx_shift <= '0;
            end
        end
    end

    assign bus.miso     = tx_shift[0];
    assign bus.tx_ready = ~hold_full;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.busy     = (state_q == SHIFT);

endmodule

// File: doc/spi_sub.md
Name: spi_sub

Overview:
- SPI subordinate endpoint that sits directly downstream of the SPI main on the AES link.
- Receives 128-bit blocks on mosi and returns a 128-bit block on miso in the same frame.
- Oversamples sclk/cs_n/mosi in the local clk domain and hands completed blocks to the AES core.
- The AES core loads the next response block through a valid/ready holding register.

Parameters:
- DATA_W, 128, frame length in bits; also the width of the data ports.
- SYNC_STAGES, 2, flip-flop stages on each of sclk, cs_n and mosi (minimum 2).

Ports:
- clk  in  1  block clock; frequency must be at least 8x the sclk frequency.
- rst  in  1  synchronous, active-high reset.
- sclk  in  1  SPI clock from the main; may run free while cs_n is high.
- cs_n  in  1  active-low frame select.
- mosi  in  1  serial data in; the main changes it on sclk rising edges.
- miso  out  1  serial data out; the main samples it on sclk falling edges.
- tx_data  in  [0:DATA_W-1]  response block from the AES core.
- tx_valid  in  1  tx_data is offered.
- tx_ready  out  1  holding register is empty.
- rx_data  out  [0:DATA_W-1]  last completed received block.
- rx_valid  out  1  one-clk pulse when rx_data updates.
- busy  out  1  high in SHIFT state.

Behaviour:
- Reset (rst sampled high on a clk rising edge) sets: miso=0, rx_data=0, rx_valid=0, tx_ready=1, busy=0, holding register empty, state=WAIT_HIGH. cs_n sync regs reset to 1; sclk and mosi sync regs reset to 0.
- Edge detection runs on the synchronized signals: sclk_fall = prev 1 and now 0; cs_fall and cs_rise are defined the same way.
- Bit order: index 0 is the first bit on the wire in both directions.
- Holding register:
  - A transfer happens when tx_valid & tx_ready on a clk edge; the register captures tx_data and tx_ready goes to 0 on the next cycle.
  - The register empties (tx_ready=1) on the frame-start cycle that consumes it.
- States:
  - WAIT_HIGH: wait for synced cs_n=1, then go to IDLE. This prevents a mid-frame reset release from joining a frame part-way through.
  - IDLE: on cs_fall, load tx_shift from the holding register (all zeros if empty), drive miso=tx_shift[0], clear bit_cnt, go to SHIFT.
  - SHIFT (busy=1): on each sclk_fall:
    - rx_shift <= {rx_shift[1:DATA_W-1], mosi_sync};
    - tx_shift shifts left by one, and miso takes the new index 0;
    - bit_cnt increments.
    - miso therefore changes 2 to SYNC_STAGES+1 clk after each sclk falling edge and is stable at the next falling edge.
  - SHIFT completion: on the sclk_fall that samples bit DATA_W-1, the next cycle has rx_data = the full block and rx_valid=1 for exactly one clk. Then go to DONE with miso=0.
  - SHIFT abort: cs_rise before bit_cnt reaches DATA_W. No rx_valid, rx_data unchanged, miso=0, go to IDLE.
  - DONE: additional sclk edges are ignored and miso stays 0. On cs_rise, go to IDLE.
- Simultaneous events:
  - tx_valid handshake in the same cycle as cs_fall: the frame loads the old register contents (zeros if empty). The new word is captured and stays for the next frame; no bypass path.
  - cs_rise and sclk_fall in the same cycle in SHIFT: cs_rise wins and the frame aborts.
  - rst has priority over everything, including mid-frame; the state returns to WAIT_HIGH.
- bit_cnt is $clog2(DATA_W)+1 bits wide and never wraps within a frame.

Optional Feature:
- Macro: SPI_SUB_ECHO_EN.
- Defined: if the holding register is empty at frame start, tx_shift loads the last completed rx_data instead of zeros. This gives a loopback path for link bring-up without the AES core. After reset the echo source is 0.
- Undefined: an empty holding register sends all zeros, and no echo storage is implied beyond rx_data.

Test Plan:
- Reset with cs_n=1 -> tx_ready=1, rx_valid=0, miso=0, busy=0; a frame started afterwards works normally.
- Load tx_data=128'h00112233445566778899AABBCCDDEEFF; main sends 128'h000102030405060708090A0B0C0D0E0F with sclk=clk/10 -> exactly one rx_valid pulse with rx_data=128'h000102...0F; main rx=128'h0011...EEFF; tx_ready returns to 1 at frame start.
- No tx word loaded, send 128'hFFFF...FF -> main receives all zeros (ECHO_EN undefined) or the previous rx_data (ECHO_EN defined); rx_data=all ones.
- Raise cs_n after 64 bits -> no rx_valid, rx_data keeps its prior value; the next full 128-bit frame completes correctly.
- Assert rst for 1 clk mid-frame while cs_n stays low for the remaining bits -> no rx_valid for that frame; the next frame after cs_n high->low completes normally.
- Assert tx_valid in the same clk as the synced cs_n fall, with the register empty -> the current frame sends zeros and the next frame sends that word.
